// File: rtl/data_ram_responder_pkg.sv
// ============================================================================
// Module : data_ram_responder_pkg
// Brief  : Shared bus widths, responder state encodings and latency helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_RAM_BUS_DEFINES
`define DATA_RAM_BUS_DEFINES
`define DATA_BUS        31:0
`define ADDR_BUS        31:0
`define MEM_SEL_BUS     3:0
`define DATA_BUS_WIDTH  32
`define ADDR_BUS_WIDTH  32
`define MEM_SEL_WIDTH   4
`define RAM_STATE_BUS   1:0
`define RAM_STATE_IDLE  2'd0
`define RAM_STATE_BUSY  2'd1
`define RAM_STATE_DONE  2'd2
`endif

package data_ram_responder_pkg;

  typedef enum logic [`RAM_STATE_BUS] {
    ST_IDLE = `RAM_STATE_IDLE,
    ST_BUSY = `RAM_STATE_BUSY,
    ST_DONE = `RAM_STATE_DONE
  } ram_state_t;

  localparam int c_MIN_LATENCY = 1;
  localparam int c_MAX_LATENCY = 15;

  // Wait-state counter start value; out-of-range latencies are clamped.
  function automatic logic [3:0] cnt_init(int lat);
    if (lat < c_MIN_LATENCY) return 4'd0;
    if (lat > c_MAX_LATENCY) return 4'(c_MAX_LATENCY - 1);
    return 4'(lat - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_responder_array.sv
// ============================================================================
// Module : data_ram_array
// Brief  : Synchronous byte-enabled word array, read-before-write, no reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_array
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [`MEM_SEL_BUS]     we,
  input  logic [ADDR_WIDTH-1:0]   index,
  input  logic [`DATA_BUS]        wdata,
  output logic [`DATA_BUS]        rdata
);

  logic [`DATA_BUS] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= r_mem[index];
      for (int i = 0; i < `MEM_SEL_WIDTH; i++) begin
        if (we[i]) r_mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_ram_responder.sv
// ============================================================================
// Module : data_ram_responder
// Brief  : Data-side RAM responder: latches one MEM-stage request, stalls for
//          LATENCY wait states, then accesses the array and releases.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                ram_en,
  input  logic [`MEM_SEL_BUS] ram_write_en,
  input  logic [`ADDR_BUS]    ram_addr,
  input  logic [`DATA_BUS]    ram_write_data,
  output logic [`DATA_BUS]    ram_read_data,
  output logic                stall_request
);

  localparam logic [3:0] c_CNT_INIT = cnt_init(LATENCY);

  ram_state_t              r_state;
  ram_state_t              w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   r_index;
  logic [`MEM_SEL_BUS]     r_we;
  logic [`DATA_BUS]        r_wdata;
  logic                    r_have_data;
  logic [`DATA_BUS]        w_rdata;
  logic                    w_accept;
  logic                    w_access;
  logic                    w_unused_addr_bits;

  assign w_unused_addr_bits = ^{ram_addr[`ADDR_BUS_WIDTH-1:ADDR_WIDTH+2], ram_addr[1:0]};

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_accept      = 1'b0;
    w_access      = 1'b0;
    stall_request = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall_request = ram_en;
        if (ram_en && !flush) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = c_CNT_INIT;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_request = 1'b1;
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_have_data <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_access) r_have_data <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_index <= ram_addr[ADDR_WIDTH+1:2];
      r_we    <= ram_write_en;
      r_wdata <= ram_write_data;
    end
  end

  // The array has no reset, so an access coinciding with rst must be suppressed.
  data_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .en    (w_access & ~rst),
    .we    (r_we),
    .index (r_index),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  // Read data reads as zero from reset until the first completed access.
  assign ram_read_data = r_have_data ? w_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_ram_responder.sv
// ============================================================================
// Module : tb_data_ram_responder
// Brief  : Directed bench for data_ram_responder (LATENCY=2 and LATENCY=1).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush,  ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr, ram_write_data, ram_read_data;
  logic        stall_request;
  logic        flush1, en1;
  logic [3:0]  we1;
  logic [31:0] addr1, wd1, rd1;
  logic        st1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_ram_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .ram_en(ram_en),
    .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .stall_request(stall_request)
  );

  data_ram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .ram_en(en1),
    .ram_write_en(we1), .ram_addr(addr1),
    .ram_write_data(wd1), .ram_read_data(rd1),
    .stall_request(st1)
  );

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered just after a rising edge; returns just after a rising edge in IDLE.
  task automatic run_req(input string name, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit chk, input logic [31:0] exp_rd,
                         input int exp_stall);
    int  n = 0;
    bit  done = 1'b0;
    ram_en = 1'b1; ram_write_en = we; ram_addr = addr; ram_write_data = wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall_request) begin
        n++;
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout: stall still high after %0d cycles", name, n);
    end
    check({name, " stall_cycles"}, 32'(n), 32'(exp_stall));
    if (chk) check({name, " rdata"}, ram_read_data, exp_rd);
    @(posedge clk); #1;
    ram_en = 1'b0; ram_write_en = 4'h0;
  endtask

  initial begin
    logic [5:0] pat;
    pat = 6'b011011;

    rst = 1'b1; flush = 1'b0; ram_en = 1'b0; ram_write_en = 4'h0;
    ram_addr = '0; ram_write_data = '0;
    flush1 = 1'b0; en1 = 1'b0; we1 = 4'h0; addr1 = '0; wd1 = '0;

    vecs[0]  = '{4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          3};
    vecs[1]  = '{4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF,  3};
    vecs[2]  = '{4'hF, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0,          3};
    vecs[3]  = '{4'h5, 32'h0000_0020, 32'hAABB_CCDD, 1'b1, 32'h1122_3344,  3};
    vecs[4]  = '{4'h0, 32'h0000_0020, 32'h0,         1'b1, 32'h11BB_33DD,  3};
    vecs[5]  = '{4'hF, 32'h0000_1003, 32'h5A5A_5A5A, 1'b0, 32'h0,          3};
    vecs[6]  = '{4'h0, 32'h0000_0000, 32'h0,         1'b1, 32'h5A5A_5A5A,  3};
    vecs[7]  = '{4'hF, 32'h0000_0014, 32'h0102_0304, 1'b0, 32'h0,          3};
    vecs[8]  = '{4'h0, 32'h0000_0017, 32'h0,         1'b1, 32'h0102_0304,  3};
    vecs[9]  = '{4'h8, 32'h0000_0014, 32'hFFFF_FFFF, 1'b1, 32'h0102_0304,  3};
    vecs[10] = '{4'h0, 32'h0000_0014, 32'h0,         1'b1, 32'hFF02_0304,  3};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset stall", 32'(stall_request), 32'h0);
    check("reset rdata", ram_read_data, 32'h0);
    check("reset stall1", 32'(st1), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      run_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].chk, vecs[i].exp_rd, vecs[i].exp_stall);

    // Reset while BUSY on a write to index 5.
    ram_en = 1'b1; ram_write_en = 4'hF; ram_addr = 32'h14; ram_write_data = 32'h9999_9999;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ram_en = 1'b0; ram_write_en = 4'h0;
    @(negedge clk);
    check("rstbusy stall", 32'(stall_request), 32'h0);
    check("rstbusy rdata", ram_read_data, 32'h0);
    @(posedge clk); #1;
    run_req("rstbusy readback", 4'h0, 32'h14, 32'h0, 1'b1, 32'hFF02_0304, 3);

    // Flush on the second stall cycle of a write.
    ram_en = 1'b1; ram_write_en = 4'hF; ram_addr = 32'h20; ram_write_data = 32'h1234_5678;
    @(negedge clk);
    check("flush stall0", 32'(stall_request), 32'h1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush stall1", 32'(stall_request), 32'h1);
    @(posedge clk); #1;
    flush = 1'b0; ram_en = 1'b0; ram_write_en = 4'h0;
    @(negedge clk);
    check("flush stall_after", 32'(stall_request), 32'h0);
    check("flush rdata_hold", ram_read_data, 32'hFF02_0304);
    @(posedge clk); #1;
    run_req("flush readback", 4'h0, 32'h20, 32'h0, 1'b1, 32'h11BB_33DD, 3);

    // Flush in IDLE with a request: stall follows ram_en, request dropped.
    ram_en = 1'b1; flush = 1'b1; ram_write_en = 4'hF; ram_addr = 32'h20; ram_write_data = 32'h0;
    @(negedge clk);
    check("idleflush stall", 32'(stall_request), 32'h1);
    @(posedge clk); #1;
    flush = 1'b0; ram_en = 1'b0; ram_write_en = 4'h0;
    @(negedge clk);
    check("idleflush stall_after", 32'(stall_request), 32'h0);
    @(posedge clk); #1;
    run_req("idleflush readback", 4'h0, 32'h20, 32'h0, 1'b1, 32'h11BB_33DD, 3);

    // LATENCY=1 back-to-back with ram_en held; data changes during first DONE.
    en1 = 1'b1; we1 = 4'hF; addr1 = 32'h08; wd1 = 32'hCAFE_F00D;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("b2b stall c%0d", i), 32'(st1), 32'(pat[i]));
      if (i == 5) check("b2b second rdata", rd1, 32'hCAFE_F00D);
      @(posedge clk); #1;
      if (i == 1) wd1 = 32'h0BAD_BEEF;
    end
    en1 = 1'b0; we1 = 4'h0;
    @(posedge clk); #1;
    en1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("b2b read stall c%0d", i), 32'(st1), 32'(pat[i]));
      if (i == 2) check("b2b read rdata", rd1, 32'h0BAD_BEEF);
      @(posedge clk); #1;
    end
    en1 = 1'b0;
    @(negedge clk);
    check("b2b idle stall", 32'(st1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
